drygascon128_seq: RTL and testbench
===================================

Name: drygascon128_seq

Overview:
- Upstream sequencer for the drygascon128 F/G core.
- Accepts 128-bit input blocks as a 32-bit valid/ready stream, each block with a 4-bit domain separator, and drives the core's word-serial load, start and readback pins.
- After each F permutation it returns the 128-bit r output as four 32-bit words on a valid/ready output stream.
- Also owns the core's synchronous active-high reset, derived from the block reset.

Parameters:
DEFAULT_ROUNDS, 11, round count used when cfg_rounds is 0
RST_SYNC_STAGES, 2, clk cycles core_rst stays high after rst_n deasserts

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_rounds  in  4  G round count, sampled at block start; 0 means DEFAULT_ROUNDS
in_data  in  32  input word; the first word of a block maps to r[31:0]
in_ds  in  4  domain separator, sampled with word 0 of each block
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid && in_ready
out_data  out  32  r output word; word 0 is r[31:0]
out_valid  out  1  output word valid
out_ready  in  1  output word consumed when out_valid && out_ready
out_last  out  1  high with the fourth output word of a block
busy  out  1  high in any state other than LOAD
core_rst  out  1  synchronous reset to the core
core_din  out  32  core din (combinational copy of in_data)
core_ds  out  4  core ds, registered, held for the whole operation
core_wr_i  out  1  core wr_i
core_start  out  1  core start
core_rounds  out  4  core rounds, registered
core_rd_r  out  1  core rd_r
core_dout  in  32  core dout (registered inside the core, valid the cycle after rd_r)
core_idle  in  1  core idle

Behaviour:
- Reset values (rst_n low), all asynchronous:
  - core_rst=1; in_ready=0; out_valid=0; out_last=0; out_data=0; busy=1.
  - core_wr_i=0; core_start=0; core_rd_r=0; core_ds=0; core_rounds=0.
  - State is RST_WAIT; word index wi=0.
- core_rst:
  - Asserts asynchronously with rst_n low.
  - Deasserts synchronously after RST_SYNC_STAGES rising edges with rst_n high.
  - The core's other control pins stay 0 while core_rst=1.
- core_wr_i = in_valid && in_ready. core_din = in_data.
- All other core pins are registered.
- States:
  - RST_WAIT: leave to LOAD on the first cycle in which core_rst is 0.
  - LOAD:
    - in_ready=1.
    - Each accepted word increments wi (2 bits). The core auto-increments its own word pointer.
    - The word accepted at wi=0 also loads core_ds<=in_ds.
    - Gaps in in_valid are allowed; wi holds across them.
    - On accepting the word at wi=3: wi wraps to 0, in_ready drops the next cycle, core_rounds<=(cfg_rounds==0 ? DEFAULT_ROUNDS : cfg_rounds), go to START.
  - START: core_start=1 for exactly this cycle; go to ARM.
  - ARM: one cycle so that core_idle is observed low; go to BUSY.
  - BUSY:
    - Wait for core_idle==1 sampled at a rising edge.
    - Then go to RD.
    - Watchdog: none.
  - RD: core_rd_r=1 for one cycle; go to CAP.
  - CAP: out_data<=core_dout, out_valid<=1, out_last<=(wi==3); go to OUT.
  - OUT:
    - Hold out_data, out_valid and out_last stable until out_ready.
    - On handshake: out_valid<=0, out_last<=0.
    - If wi==3: wi<=0, go to LOAD.
    - Else: wi<=wi+1, go to RD.
- Readback:
  - Exactly one core_rd_r pulse per output word, and exactly 4 per block.
  - No rd_r is issued while a word is pending, so backpressure never skips a word.
- core_wr_i, core_start and core_rd_r are mutually exclusive in every cycle.
- core_ds is held from word 0 of a block until the next block's word 0. The core samples ds during its mix phase.
- Throughput:
  - Per block: 4 input cycles minimum, +2 (START, ARM), + core busy time, +3 cycles per output word with out_ready held high.
- Boundary conditions:
  - out_ready held high in CAP is ignored; a handshake only counts in OUT.
  - in_valid while not in LOAD: not accepted (in_ready=0).
  - rst_n low in any state: immediate return to reset values. core_rst re-asserts, the core returns to idle, and a partially loaded or in-flight block is discarded.
  - cfg_rounds changes mid-operation have no effect; it is sampled only at the transition to START.

Test Plan:
- Reset release: rst_n low 3 cycles then high -> core_rst high through 2 edges after release, then 0; in_ready=1 the cycle after core_rst falls; busy=0.
- Load block 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with in_ds=4 on word 0 and cfg_rounds=0 -> 4 core_wr_i pulses with matching core_din; core_start one cycle after the last word; core_ds=4; core_rounds=11.
- Full block against the drygascon128 core model, with out_ready held high -> 4 output words matching the reference r, out_last only on word 4, exactly 4 core_rd_r pulses, then in_ready=1.
- Input gaps (in_valid low 3 cycles between words 1 and 2) and cfg_rounds=7 -> words still land in order; core_rounds=7.
- Output backpressure: out_ready low 5 cycles on word 2 -> out_data stable throughout, no core_rd_r pulses while stalled, words unchanged and in order.
- rst_n low during BUSY, then a fresh block -> all outputs at reset values, core_rst asserted, no output from the aborted block; the next block produces correct r.

Source files
------------

// File: rtl/drygascon128_seq.sv
// Upstream sequencer for the drygascon128 F/G core: streams 128-bit blocks into the core,
// starts it, and reads the 128-bit r result back out as four 32-bit words.
module drygascon128_seq #(
    parameter int DEFAULT_ROUNDS  = 11,
    parameter int RST_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  cfg_rounds,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_ds,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        core_rst,
    output logic [31:0] core_din,
    output logic [3:0]  core_ds,
    output logic        core_wr_i,
    output logic        core_start,
    output logic [3:0]  core_rounds,
    output logic        core_rd_r,
    input  logic [31:0] core_dout,
    input  logic        core_idle
);

    typedef enum logic [2:0] {
        RST_WAIT,
        LOAD,
        START,
        ARM,
        BUSY,
        RD,
        CAP,
        OUT
    } state_t;

    state_t                     state;
    state_t                     state_nx;
    logic [RST_SYNC_STAGES-1:0] rst_sync;
    logic [1:0]                 wi;
    logic                       in_fire;
    logic                       out_fire;

    assign core_rst  = rst_sync[RST_SYNC_STAGES-1];
    assign in_ready  = (state == LOAD);
    assign in_fire   = in_valid && in_ready;
    assign core_wr_i = in_fire;
    assign core_din  = in_data;
    assign busy      = (state != LOAD);
    assign out_fire  = (state == OUT) && out_valid && out_ready;

    // Core reset releases only after RST_SYNC_STAGES clean edges; zeros shift in from the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '1;
        end else begin
            rst_sync <= rst_sync << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_WAIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            RST_WAIT: if (!core_rst) state_nx = LOAD;
            LOAD:     if (in_fire && (wi == 2'd3)) state_nx = START;
            START:    state_nx = ARM;
            ARM:      state_nx = BUSY;
            BUSY:     if (core_idle) state_nx = RD;
            RD:       state_nx = CAP;
            CAP:      state_nx = OUT;
            OUT:      if (out_fire) state_nx = (wi == 2'd3) ? LOAD : RD;
            default:  state_nx = RST_WAIT;
        endcase
    end

    // Strobes are registered from the next state so they line up exactly with START and RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wi          <= 2'd0;
            core_ds     <= 4'd0;
            core_rounds <= 4'd0;
            core_start  <= 1'b0;
            core_rd_r   <= 1'b0;
            out_data    <= 32'd0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            core_start <= (state_nx == START);
            core_rd_r  <= (state_nx == RD);

            if (in_fire) begin
                wi <= wi + 2'd1;
                if (wi == 2'd0) begin
                    core_ds <= in_ds;
                end
                if (wi == 2'd3) begin
                    core_rounds <= (cfg_rounds == 4'd0) ? 4'(DEFAULT_ROUNDS) : cfg_rounds;
                end
            end

            if (state == CAP) begin
                out_data  <= core_dout;
                out_valid <= 1'b1;
                out_last  <= (wi == 2'd3);
            end

            // The 2-bit index wraps 3 -> 0 on the last output word.
            if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                wi        <= wi + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_drygascon128_seq.sv
// Self-checking bench for drygascon128_seq with a behavioural stand-in for the F/G core
// whose r output is r[i] = w[(i+1)%4] ^ {rounds, ds}, so expected words are easy to hand-derive.
module tb_drygascon128_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cfg_rounds = 4'd0;
    logic [31:0] in_data = 32'd0;
    logic [3:0]  in_ds = 4'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        busy;
    logic        core_rst;
    logic [31:0] core_din;
    logic [3:0]  core_ds;
    logic        core_wr_i;
    logic        core_start;
    logic [3:0]  core_rounds;
    logic        core_rd_r;
    logic [31:0] core_dout = 32'd0;
    logic        core_idle = 1'b1;

    always #5 clk = ~clk;

    drygascon128_seq #(.DEFAULT_ROUNDS(11), .RST_SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_rounds(cfg_rounds),
        .in_data(in_data), .in_ds(in_ds), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .core_rst(core_rst), .core_din(core_din), .core_ds(core_ds),
        .core_wr_i(core_wr_i), .core_start(core_start), .core_rounds(core_rounds),
        .core_rd_r(core_rd_r), .core_dout(core_dout), .core_idle(core_idle)
    );

    // Core stand-in: word-serial load, busy for 'rounds' cycles, registered readback.
    logic [31:0] cw [4];
    logic [31:0] cr [4];
    logic [1:0]  wp = 2'd0;
    logic [1:0]  rp = 2'd0;
    logic        running = 1'b0;
    int          cnt = 0;

    always @(posedge clk) begin
        if (core_rst) begin
            wp <= 2'd0; rp <= 2'd0; running <= 1'b0; core_idle <= 1'b1; core_dout <= 32'd0;
        end else begin
            if (core_wr_i) begin
                cw[wp] <= core_din;
                wp     <= wp + 2'd1;
            end
            if (core_start) begin
                running <= 1'b1; core_idle <= 1'b0; cnt <= int'(core_rounds); rp <= 2'd0; wp <= 2'd0;
            end else if (running) begin
                if (cnt <= 1) begin
                    running <= 1'b0;
                    core_idle <= 1'b1;
                    for (int i = 0; i < 4; i++) cr[i] <= cw[(i + 1) % 4] ^ {24'h0, core_rounds, core_ds};
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (core_rd_r) begin
                core_dout <= cr[rp];
                rp        <= rp + 2'd1;
            end
        end
    end

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t        sb [$];
    int          compared = 0;
    int          mismatched = 0;
    int          popped = 0;
    int          wr_count = 0;
    int          rd_count = 0;
    int          rd_pending_bad = 0;
    int          excl_bad = 0;
    logic        held = 1'b0;
    logic [31:0] held_d = 32'd0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and watches pin-level rules.
    always @(negedge clk) begin
        exp_t e;
        if (core_wr_i) wr_count++;
        if (core_rd_r) begin
            rd_count++;
            if (out_valid) rd_pending_bad++;
        end
        if ((int'(core_wr_i) + int'(core_start) + int'(core_rd_r)) > 1) excl_bad++;
        if (out_valid && out_ready) begin
            checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("out_data", out_data, e.d);
                checkOutput("out_last", 32'(out_last), 32'(e.l));
                popped++;
            end
            held = 1'b0;
        end else if (out_valid) begin
            if (held) checkOutput("stall_stable", out_data, held_d);
            held   = 1'b1;
            held_d = out_data;
        end else begin
            held = 1'b0;
        end
    end

    task automatic applyStimulus(input logic [127:0] blk, input logic [3:0] ds, input logic [3:0] rounds,
                                 input bit gap, input logic [127:0] r, input bit expect_out);
        int tmo;
        exp_t e;
        wr_count   = 0;
        rd_count   = 0;
        cfg_rounds = rounds;
        if (expect_out) begin
            for (int i = 0; i < 4; i++) begin
                e.d = r[32*i +: 32];
                e.l = (i == 3);
                sb.push_back(e);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (gap && i == 2) begin
                in_valid = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = blk[32*i +: 32];
            in_ds    = (i == 0) ? ds : 4'hF;
            tmo = 0;
            while (!in_ready && tmo < 200) begin
                @(posedge clk); #1; tmo++;
            end
            if (tmo >= 200) checkOutput("in_ready_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_ds    = 4'h0;
        checkOutput("start_pulse", 32'({core_start, in_ready, core_wr_i}), 32'b100);
        checkOutput("wr_count", 32'(wr_count), 32'd4);
        checkOutput("core_ds", 32'(core_ds), 32'(ds));
        checkOutput("core_rounds", 32'(core_rounds), (rounds == 4'd0) ? 32'd11 : 32'(rounds));
    endtask

    task automatic waitDone(input int target);
        int tmo = 0;
        while (popped < target && tmo < 1000) begin
            @(posedge clk); #1; tmo++;
        end
        checkOutput("block_done", 32'(popped), 32'(target));
        checkOutput("rd_count", 32'(rd_count), 32'd4);
        checkOutput("in_ready_after", 32'({in_ready, busy}), 32'b10);
    endtask

    initial begin
        int tmo;
        int base;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctrl",
            32'({core_rst, in_ready, out_valid, out_last, busy, core_wr_i, core_start, core_rd_r}),
            32'b1000_1000);
        checkOutput("reset_regs", 32'({core_ds, core_rounds}), 32'd0);
        checkOutput("reset_out_data", out_data, 32'd0);

        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("core_rst_edge1", 32'(core_rst), 32'd1);
        @(posedge clk); #1;
        checkOutput("core_rst_edge2", 32'({core_rst, in_ready}), 32'b00);
        @(posedge clk); #1;
        checkOutput("load_entry", 32'({in_ready, busy}), 32'b10);

        // Block 1: default rounds, ds=4; cfg_rounds changed after start must not matter.
        applyStimulus({32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100}, 4'h4, 4'h0, 1'b0,
                      {32'h030201B4, 32'h0F0E0DB8, 32'h0B0A09BC, 32'h070605B0}, 1'b1);
        cfg_rounds = 4'h9;
        waitDone(4);

        // Block 2: input gap, rounds=7, ds=A, backpressure on the second output word.
        base = popped;
        applyStimulus({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4'hA, 4'h7, 1'b1,
                      {32'h1111116B, 32'h4444443E, 32'h33333349, 32'h22222258}, 1'b1);
        tmo = 0;
        while (!(out_valid && popped == base + 1) && tmo < 500) begin
            @(posedge clk); #1; tmo++;
        end
        checkOutput("stall_reached", 32'(popped), 32'(base + 1));
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rd_during_stall", 32'(rd_count), 32'd2);
        out_ready = 1'b1;
        waitDone(base + 4);

        // Aborted block: reset arrives while the core is busy.
        base = popped;
        applyStimulus({32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0}, 4'h2, 4'h5, 1'b0,
                      128'd0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("abort_busy", 32'({busy, core_idle}), 32'b10);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_reset_ctrl",
            32'({core_rst, in_ready, out_valid, out_last, busy, core_wr_i, core_start, core_rd_r}),
            32'b1000_1000);
        checkOutput("abort_reset_regs", 32'({core_ds, core_rounds}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tmo = 0;
        while (!in_ready && tmo < 20) begin
            @(posedge clk); #1; tmo++;
        end
        checkOutput("abort_reload", 32'(in_ready), 32'd1);
        checkOutput("abort_no_output", 32'(popped), 32'(base));

        // Fresh block after the abort.
        applyStimulus({32'hD0D0D0D0, 32'hC0C0C0C0, 32'hB0B0B0B0, 32'hA0A0A0A0}, 4'h1, 4'h3, 1'b0,
                      {32'hA0A0A091, 32'hD0D0D0E1, 32'hC0C0C0F1, 32'hB0B0B081}, 1'b1);
        waitDone(base + 4);

        checkOutput("rd_while_pending", 32'(rd_pending_bad), 32'd0);
        checkOutput("strobe_exclusive", 32'(excl_bad), 32'd0);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
